aurora_gt_lane_router: RTL and testbench

//  Parametrised successor to the fixed 2-of-4 GT pin pass-through between the QSFP GT serial port and the Aurora core.

---
 rtl/aurora_gt_pkg.sv | 23 ++
 rtl/aurora_gt_lane_router_if.sv | 25 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/aurora_gt_lane_router.sv | 165 ++++++++++++++++
 tb/tb_aurora_gt_lane_router.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/aurora_gt_pkg.sv
// Shared types and helpers for the Aurora GT lane router.
//  state_t          : lane router supervisor states
//  IDLE_TXP/TXN     : static level driven on GT TX lanes outside the active window
//  lane_base_valid(): checks that a requested window fits inside the GT lanes
package aurora_gt_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        WAIT_UP  = 2'd1,
        UP       = 2'd2
    } state_t;

    localparam logic IDLE_TXP = 1'b0;
    localparam logic IDLE_TXN = 1'b1;

    // A window starting at base is usable only if all Aurora lanes land on real GT lanes.
    function automatic logic lane_base_valid(input int unsigned base,
                                             input int unsigned n_aurora,
                                             input int unsigned n_gt);
        return (base + n_aurora) <= n_gt;
    endfunction

endpackage

// File: rtl/aurora_gt_lane_router_if.sv
// Control/status bundle between kernel control logic (master) and the lane router (slave).
//  cfg_valid/cfg_ready/cfg_lane_base : remap request handshake
//  cfg_err                           : one-cycle reject pulse for an out-of-range base
//  status_*                          : link state, active window base, retry count
interface aurora_gt_lane_router_if #(
    parameter int unsigned SEL_W = 2
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_lane_base;
    logic             cfg_err;
    logic             status_link_up;
    logic [SEL_W-1:0] status_lane_base;
    logic [7:0]       status_retry_cnt;

    modport master (
        output cfg_valid, cfg_lane_base,
        input  cfg_ready, cfg_err, status_link_up, status_lane_base, status_retry_cnt
    );

    modport slave (
        input  cfg_valid, cfg_lane_base,
        output cfg_ready, cfg_err, status_link_up, status_lane_base, status_retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//  clk, rst_n : destination clock and synchronous active-low reset
//  d          : asynchronous input
//  q          : synchronised output (2-3 cycle latency)
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;
endmodule

// File: rtl/aurora_gt_lane_router.sv
// Routes NUM_AURORA_LANES contiguous Aurora lanes onto a runtime-selectable window of
// the QSFP GT lanes, sequences the Aurora reset around each remap and supervises
// channel-up with timeout and automatic retry.
//  ap_clk, ap_rst_n          : control clock, synchronous active-low reset
//  GT_SERIAL_RX/TX_*         : board GT serial pins
//  AuroraGT_rx*/tx*          : Aurora core serial pins
//  cfg                       : remap request handshake and status (slave side)
//  aurora_reset              : Aurora reset_pb/pma_init, active high
//  aurora_channel_up         : Aurora channel_up, asynchronous to ap_clk
module aurora_gt_lane_router
    import aurora_gt_pkg::*;
#(
    parameter int unsigned NUM_GT_LANES      = 4,
    parameter int unsigned NUM_AURORA_LANES  = 2,
    parameter int unsigned DEFAULT_BASE      = 0,
    parameter int unsigned RESET_HOLD_CYCLES = 256,
    parameter int unsigned UP_TIMEOUT        = 1048576,
    parameter int unsigned SEL_W             = (NUM_GT_LANES > 1) ? $clog2(NUM_GT_LANES) : 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_GT_LANES-1:0]     GT_SERIAL_RX_rxp,
    input  logic [NUM_GT_LANES-1:0]     GT_SERIAL_RX_rxn,
    output logic [NUM_GT_LANES-1:0]     GT_SERIAL_TX_txp,
    output logic [NUM_GT_LANES-1:0]     GT_SERIAL_TX_txn,
    output logic [NUM_AURORA_LANES-1:0] AuroraGT_rxp,
    output logic [NUM_AURORA_LANES-1:0] AuroraGT_rxn,
    input  logic [NUM_AURORA_LANES-1:0] AuroraGT_txp,
    input  logic [NUM_AURORA_LANES-1:0] AuroraGT_txn,
    aurora_gt_lane_router_if.slave      cfg,
    output logic                        aurora_reset,
    input  logic                        aurora_channel_up
);

    localparam int unsigned HOLD_W = (RESET_HOLD_CYCLES > 2) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int unsigned TO_W   = $clog2(UP_TIMEOUT);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic [SEL_W-1:0]  active_base, base_nxt;
    logic [7:0]        retry_cnt, retry_nxt;
    logic              err_nxt;
    logic              cu_s;
    logic              accept_c;

    logic              aurora_reset_q;
    logic              cfg_ready_q;
    logic              cfg_err_q;
    logic              link_up_q;

    // Channel-up crosses into ap_clk here.
    sync_2ff u_cu_sync (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .d     (aurora_channel_up),
        .q     (cu_s)
    );

    // cfg_ready_q is high exactly while the FSM is in WAIT_UP or UP.
    assign accept_c = cfg.cfg_valid && cfg_ready_q;

    // Next-state, counters and request handling; an accepted request overrides
    // any timeout or channel-up transition in the same cycle.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        to_nxt    = to_cnt;
        base_nxt  = active_base;
        retry_nxt = retry_cnt;
        err_nxt   = 1'b0;

        case (state)
            RST_HOLD: begin
                hold_nxt = hold_cnt + HOLD_W'(1);
                if (hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
                    state_nxt = WAIT_UP;
                    to_nxt    = '0;
                end
            end
            WAIT_UP: begin
                to_nxt = to_cnt + TO_W'(1);
                if (cu_s) begin
                    state_nxt = UP;
                end else if (to_cnt == TO_W'(UP_TIMEOUT - 1)) begin
                    state_nxt = RST_HOLD;
                    hold_nxt  = '0;
                    retry_nxt = (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
                end
            end
            UP: begin
                if (!cu_s) begin
                    state_nxt = WAIT_UP;
                    to_nxt    = '0;
                end
            end
            default: begin
                state_nxt = RST_HOLD;
                hold_nxt  = '0;
            end
        endcase

        if (accept_c) begin
            if (lane_base_valid(32'(cfg.cfg_lane_base), NUM_AURORA_LANES, NUM_GT_LANES)) begin
                state_nxt = RST_HOLD;
                hold_nxt  = '0;
                base_nxt  = cfg.cfg_lane_base;
                retry_nxt = '0;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state          <= RST_HOLD;
            hold_cnt       <= '0;
            to_cnt         <= '0;
            active_base    <= SEL_W'(DEFAULT_BASE);
            retry_cnt      <= '0;
            aurora_reset_q <= 1'b1;
            cfg_ready_q    <= 1'b0;
            cfg_err_q      <= 1'b0;
            link_up_q      <= 1'b0;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_nxt;
            to_cnt         <= to_nxt;
            active_base    <= base_nxt;
            retry_cnt      <= retry_nxt;
            aurora_reset_q <= (state_nxt == RST_HOLD);
            cfg_ready_q    <= (state_nxt != RST_HOLD);
            cfg_err_q      <= err_nxt;
            link_up_q      <= (state_nxt == UP);
        end
    end

    assign aurora_reset          = aurora_reset_q;
    assign cfg.cfg_ready         = cfg_ready_q;
    assign cfg.cfg_err           = cfg_err_q;
    assign cfg.status_link_up    = link_up_q;
    assign cfg.status_lane_base  = active_base;
    assign cfg.status_retry_cnt  = retry_cnt;

    // RX: Aurora lane i takes GT lane active_base+i.
    assign AuroraGT_rxp = NUM_AURORA_LANES'(GT_SERIAL_RX_rxp >> active_base);
    assign AuroraGT_rxn = NUM_AURORA_LANES'(GT_SERIAL_RX_rxn >> active_base);

    // TX: Aurora lanes shifted into the window; lanes outside it sit at static idle.
    logic [NUM_GT_LANES-1:0] win_mask;
    logic [NUM_GT_LANES-1:0] tx_p_sh;
    logic [NUM_GT_LANES-1:0] tx_n_sh;

    assign win_mask = NUM_GT_LANES'({NUM_AURORA_LANES{1'b1}}) << active_base;
    assign tx_p_sh  = NUM_GT_LANES'(AuroraGT_txp) << active_base;
    assign tx_n_sh  = NUM_GT_LANES'(AuroraGT_txn) << active_base;

    for (genvar g = 0; g < NUM_GT_LANES; g++) begin : g_gt_tx
        assign GT_SERIAL_TX_txp[g] = win_mask[g] ? tx_p_sh[g] : IDLE_TXP;
        assign GT_SERIAL_TX_txn[g] = win_mask[g] ? tx_n_sh[g] : IDLE_TXN;
    end

endmodule

// File: tb/tb_aurora_gt_lane_router.sv
// Directed bench for aurora_gt_lane_router with HOLD=8, TIMEOUT=64.
module tb_aurora_gt_lane_router;

    localparam int unsigned NGT  = 4;
    localparam int unsigned NAUR = 2;
    localparam int unsigned SW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NGT-1:0]  gt_rxp, gt_rxn, gt_txp, gt_txn;
    logic [NAUR-1:0] aur_rxp, aur_rxn, aur_txp, aur_txn;
    logic            aur_rst;
    logic            chan_up;

    int total = 0;
    int bad   = 0;

    aurora_gt_lane_router_if #(.SEL_W(SW)) cfg_if ();

    aurora_gt_lane_router #(
        .NUM_GT_LANES      (NGT),
        .NUM_AURORA_LANES  (NAUR),
        .DEFAULT_BASE      (0),
        .RESET_HOLD_CYCLES (8),
        .UP_TIMEOUT        (64),
        .SEL_W             (SW)
    ) dut (
        .ap_clk            (clk),
        .ap_rst_n          (rst_n),
        .GT_SERIAL_RX_rxp  (gt_rxp),
        .GT_SERIAL_RX_rxn  (gt_rxn),
        .GT_SERIAL_TX_txp  (gt_txp),
        .GT_SERIAL_TX_txn  (gt_txn),
        .AuroraGT_rxp      (aur_rxp),
        .AuroraGT_rxn      (aur_rxn),
        .AuroraGT_txp      (aur_txp),
        .AuroraGT_txn      (aur_txn),
        .cfg               (cfg_if.slave),
        .aurora_reset      (aur_rst),
        .aurora_channel_up (chan_up)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        chan_up              = 1'b0;
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_lane_base = '0;
        gt_rxp  = 4'b0110;
        gt_rxn  = 4'b1001;
        aur_txp = 2'b01;
        aur_txn = 2'b10;
        tick(3);

        // Reset state
        chk("rst_aurora_reset", 32'(aur_rst), 32'(1));
        chk("rst_cfg_ready",    32'(cfg_if.cfg_ready), 32'(0));
        chk("rst_cfg_err",      32'(cfg_if.cfg_err), 32'(0));
        chk("rst_link_up",      32'(cfg_if.status_link_up), 32'(0));
        chk("rst_lane_base",    32'(cfg_if.status_lane_base), 32'(0));
        chk("rst_retry",        32'(cfg_if.status_retry_cnt), 32'(0));

        // 1: reset hold of 8 cycles after release, then channel-up
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("t1_hold_reset", 32'(aur_rst), 32'(1));
        end
        chk("t1_hold_ready", 32'(cfg_if.cfg_ready), 32'(0));
        tick(1);
        chk("t1_release_reset", 32'(aur_rst), 32'(0));
        chk("t1_release_ready", 32'(cfg_if.cfg_ready), 32'(1));
        chk("t1_aur_rxp", 32'(aur_rxp), 32'(2'b10));
        chk("t1_aur_rxn", 32'(aur_rxn), 32'(2'b01));
        chk("t1_gt_txp",  32'(gt_txp), 32'(4'b0001));
        chk("t1_gt_txn",  32'(gt_txn), 32'(4'b1110));
        tick(12);
        chan_up = 1'b1;
        tick(2);
        chk("t1_link_early", 32'(cfg_if.status_link_up), 32'(0));
        tick(1);
        chk("t1_link_up", 32'(cfg_if.status_link_up), 32'(1));

        // 2: remap to base 2
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_lane_base = 2'd2;
        tick(1);
        cfg_if.cfg_valid = 1'b0;
        chk("t2_reset",     32'(aur_rst), 32'(1));
        chk("t2_ready",     32'(cfg_if.cfg_ready), 32'(0));
        chk("t2_link",      32'(cfg_if.status_link_up), 32'(0));
        chk("t2_lane_base", 32'(cfg_if.status_lane_base), 32'(2));
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            chk("t2_hold_reset", 32'(aur_rst), 32'(1));
        end
        tick(1);
        chk("t2_release_reset", 32'(aur_rst), 32'(0));
        tick(1);
        chk("t2_link_up", 32'(cfg_if.status_link_up), 32'(1));
        chk("t2_aur_rxp", 32'(aur_rxp), 32'(2'b01));
        chk("t2_aur_rxn", 32'(aur_rxn), 32'(2'b10));
        chk("t2_gt_txp",  32'(gt_txp), 32'(4'b0100));
        chk("t2_gt_txn",  32'(gt_txn), 32'(4'b1011));

        // 3: out-of-range base 3 is rejected
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_lane_base = 2'd3;
        tick(1);
        cfg_if.cfg_valid = 1'b0;
        chk("t3_err",       32'(cfg_if.cfg_err), 32'(1));
        chk("t3_reset",     32'(aur_rst), 32'(0));
        chk("t3_link",      32'(cfg_if.status_link_up), 32'(1));
        chk("t3_lane_base", 32'(cfg_if.status_lane_base), 32'(2));
        chk("t3_gt_txp",    32'(gt_txp), 32'(4'b0100));
        tick(1);
        chk("t3_err_clear", 32'(cfg_if.cfg_err), 32'(0));

        // 5: channel-up drop returns to WAIT_UP without reset until timeout
        chan_up = 1'b0;
        tick(2);
        chk("t5_link_still", 32'(cfg_if.status_link_up), 32'(1));
        tick(1);
        chk("t5_link_down", 32'(cfg_if.status_link_up), 32'(0));
        chk("t5_no_reset",  32'(aur_rst), 32'(0));
        chk("t5_ready",     32'(cfg_if.cfg_ready), 32'(1));
        tick(63);
        chk("t5_pre_timeout", 32'(aur_rst), 32'(0));
        chk("t5_retry0",      32'(cfg_if.status_retry_cnt), 32'(0));
        tick(1);
        chk("t5_timeout_reset", 32'(aur_rst), 32'(1));
        chk("t5_retry1",        32'(cfg_if.status_retry_cnt), 32'(1));

        // 4: retries every 72 cycles, saturating at 255
        tick(71);
        chk("t4_pre_retry_reset", 32'(aur_rst), 32'(0));
        chk("t4_pre_retry_cnt",   32'(cfg_if.status_retry_cnt), 32'(1));
        tick(1);
        chk("t4_retry2_reset", 32'(aur_rst), 32'(1));
        chk("t4_retry2",       32'(cfg_if.status_retry_cnt), 32'(2));
        tick(72);
        chk("t4_retry3", 32'(cfg_if.status_retry_cnt), 32'(3));
        repeat (252) tick(72);
        chk("t4_retry255",       32'(cfg_if.status_retry_cnt), 32'(255));
        chk("t4_retry255_reset", 32'(aur_rst), 32'(1));
        tick(72);
        chk("t4_retry_sat", 32'(cfg_if.status_retry_cnt), 32'(255));

        // 6: same-base remap, then reset aborts the hold
        tick(8);
        chk("t6_ready", 32'(cfg_if.cfg_ready), 32'(1));
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_lane_base = 2'd2;
        tick(1);
        cfg_if.cfg_valid = 1'b0;
        chk("t6_remap_reset", 32'(aur_rst), 32'(1));
        chk("t6_retry_clear", 32'(cfg_if.status_retry_cnt), 32'(0));
        chk("t6_lane_base",   32'(cfg_if.status_lane_base), 32'(2));
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst_base",  32'(cfg_if.status_lane_base), 32'(0));
        chk("t6_rst_reset", 32'(aur_rst), 32'(1));
        chk("t6_rst_ready", 32'(cfg_if.cfg_ready), 32'(0));
        chk("t6_rst_txp",   32'(gt_txp), 32'(4'b0001));
        rst_n = 1'b1;
        tick(7);
        chk("t6_hold_restart", 32'(aur_rst), 32'(1));
        tick(1);
        chk("t6_hold_done", 32'(aur_rst), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
